// File: rtl/gpio_irq_if.sv
// Register bus between the CPU I/O decode and the GPIO block.
interface gpio_irq_if;
  logic        sel;
  logic        wr;
  logic [2:0]  adr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, wr, adr, wdata, input rdata);
  modport slave  (input sel, wr, adr, wdata, output rdata);
endinterface

// File: rtl/gpio_irq.sv
// GPIO controller: direction, atomic set/clear, synchronised inputs and
// sticky edge interrupts. Per-pin input logic lives in gpio_irq_pin.

// One pin's input path: synchroniser, edge detector and sticky status bit.
module gpio_irq_pin #(
  parameter int SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic       armed,
  input  logic [1:0] mode,
  input  logic       w1c,
  output logic       sin,
  output logic       status
);
  logic [SYNC-1:0] sync;
  logic            prev;
  logic            rise, fall, ev;

  assign sin  = sync[SYNC-1];
  assign rise = sin & ~prev;
  assign fall = ~sin & prev;
  // mode[0] selects rising, mode[1] falling; armed masks the start-up ramp
  assign ev   = armed & ((mode[0] & rise) | (mode[1] & fall));

  // Shift pin through the synchroniser; a same-cycle event beats the W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      prev   <= 1'b0;
      status <= 1'b0;
    end else begin
      sync   <= {sync[SYNC-2:0], pin};
      prev   <= sin;
      status <= (status & ~w1c) | ev;
    end
  end
endmodule

module gpio_irq #(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  gpio_irq_if.slave     bus,
  input  logic [W-1:0]  pin_in,
  output logic [W-1:0]  pin_out,
  output logic [W-1:0]  pin_oe,
  output logic          irq
);
  localparam logic [2:0] ARM = 3'(SYNC + 1);

  localparam logic [2:0] A_DATA = 3'd0, A_OE   = 3'd1, A_SET  = 3'd2, A_CLR = 3'd3,
                         A_IE   = 3'd4, A_MODE = 3'd5, A_STAT = 3'd6, A_PEND = 3'd7;

  logic [W-1:0]   out, oe, ie, sin, status, w1c, pend;
  logic [2*W-1:0] mode;
  logic [2:0]     arm_cnt;
  logic           armed, wen;

  assign wen   = bus.sel & bus.wr;
  assign armed = (arm_cnt == ARM);
  assign w1c   = (wen && bus.adr == A_STAT) ? bus.wdata[W-1:0] : '0;
  assign pend  = status & ie;

  assign pin_out = out;
  assign pin_oe  = oe;
  assign irq     = |pend;

  // Hold off edge detection until the synchroniser and prev hold real pin data
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 3'd1;
  end

  // Bus writes to the control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      oe   <= '0;
      ie   <= '0;
      mode <= '0;
    end else if (wen) begin
      case (bus.adr)
        A_DATA: out  <= bus.wdata[W-1:0];
        A_OE:   oe   <= bus.wdata[W-1:0];
        A_SET:  out  <= out | bus.wdata[W-1:0];
        A_CLR:  out  <= out & ~bus.wdata[W-1:0];
        A_IE:   ie   <= bus.wdata[W-1:0];
        A_MODE: mode <= bus.wdata[2*W-1:0];
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_pin
    gpio_irq_pin #(.SYNC(SYNC)) u_pin (
      .clk    (clk),
      .rst    (rst),
      .pin    (pin_in[i]),
      .armed  (armed),
      .mode   (mode[2*i+1:2*i]),
      .w1c    (w1c[i]),
      .sin    (sin[i]),
      .status (status[i])
    );
  end

  // Combinational read mux; unused upper bits read as zero
  always_comb begin
    bus.rdata = '0;
    case (bus.adr)
      A_DATA: bus.rdata = 32'(sin);
      A_OE:   bus.rdata = 32'(oe);
      A_SET,
      A_CLR:  bus.rdata = 32'(out);
      A_IE:   bus.rdata = 32'(ie);
      A_MODE: bus.rdata = 32'(mode);
      A_STAT: bus.rdata = 32'(status);
      A_PEND: bus.rdata = {8'(W), 8'd0, 16'(pend)};
      default: bus.rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq: vector table, directed edge/reset sequences, and a
// random run against a pin-history reference model.
module tb_gpio_irq;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pin_in = 8'hFF;
  logic [7:0]  pin_out, pin_oe;
  logic        irq;
  logic [15:0] pin16_in = 16'h0;
  logic [15:0] pin16_out, pin16_oe;
  logic        irq16;

  gpio_irq_if bus();
  gpio_irq_if bus16();

  gpio_irq #(.W(8), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq));

  gpio_irq #(.W(16), .SYNC(SYNC)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .pin_in(pin16_in),
    .pin_out(pin16_out), .pin_oe(pin16_oe), .irq(irq16));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.adr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.adr = a;
    #1 d = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  adr;
    logic [31:0] wdata;
    logic [2:0]  radr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;
  vec_t tbl[7];

  // Reference model: register image plus a history of sampled pin values.
  // The value sampled SYNC edges back is what the block sees as the pin now,
  // the one before that is the previous value.
  logic [7:0]  m_out, m_oe, m_ie, m_st;
  logic [15:0] m_mode;
  logic [7:0]  hist[$];
  int          ecnt;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, hist[1]};
      3'd1: return {24'd0, m_oe};
      3'd2, 3'd3: return {24'd0, m_out};
      3'd4: return {24'd0, m_ie};
      3'd5: return {16'd0, m_mode};
      3'd6: return {24'd0, m_st};
      default: return {8'd8, 16'd0, m_st & m_ie};
    endcase
  endfunction

  task automatic m_reset();
    m_out = 0; m_oe = 0; m_ie = 0; m_st = 0; m_mode = 0; ecnt = 0;
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(8'h00);
  endtask

  task automatic m_edge(input logic s, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [7:0] p);
    logic [7:0] cur, old, ev;
    cur = hist[1]; old = hist[0]; ev = 0;
    for (int i = 0; i < 8; i++) begin
      if (ecnt >= SYNC + 1) begin
        if (m_mode[2*i]   && cur[i] && !old[i]) ev[i] = 1'b1;
        if (m_mode[2*i+1] && !cur[i] && old[i]) ev[i] = 1'b1;
      end
    end
    if (s && w && a == 3'd6) m_st = (m_st & ~d[7:0]) | ev;
    else                     m_st = m_st | ev;
    if (s && w) begin
      case (a)
        3'd0: m_out = d[7:0];
        3'd1: m_oe = d[7:0];
        3'd2: m_out = m_out | d[7:0];
        3'd3: m_out = m_out & ~d[7:0];
        3'd4: m_ie = d[7:0];
        3'd5: m_mode = d[15:0];
        default: ;
      endcase
    end
    hist.push_back(p);
    void'(hist.pop_front());
    ecnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        s, w;
    logic [2:0]  a;
    logic [31:0] d;

    bus.sel = 0; bus.wr = 0; bus.adr = 0; bus.wdata = 0;
    bus16.sel = 0; bus16.wr = 0; bus16.adr = 0; bus16.wdata = 0;

    tbl[0] = '{3'd0, 32'h0000_00A5, 3'd2, 32'h0000_00A5, 8'hA5};
    tbl[1] = '{3'd2, 32'h0000_000A, 3'd3, 32'h0000_00AF, 8'hAF};
    tbl[2] = '{3'd3, 32'h0000_0021, 3'd2, 32'h0000_008E, 8'h8E};
    tbl[3] = '{3'd1, 32'hFFFF_FF3C, 3'd1, 32'h0000_003C, 8'h8E};
    tbl[4] = '{3'd4, 32'h0000_01FF, 3'd4, 32'h0000_00FF, 8'h8E};
    tbl[5] = '{3'd5, 32'h1234_5678, 3'd5, 32'h0000_5678, 8'h8E};
    tbl[6] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0800_0000, 8'h8E};

    // Reset state with all pins high
    #3;
    chk("reset pin_out", 32'(pin_out), 32'h0);
    chk("reset pin_oe", 32'(pin_oe), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    @(negedge clk) rst = 1'b0;
    cycles(10);
    rd_reg(3'd6, rd); chk("no spurious status", rd, 32'h0);

    // Register vector table
    for (int i = 0; i < 7; i++) begin
      wr_reg(tbl[i].adr, tbl[i].wdata);
      rd_reg(tbl[i].radr, rd);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d pin_out", i), 32'(pin_out), 32'(tbl[i].exp_out));
    end

    // Rising-edge latency on pin 0
    wr_reg(3'd5, 32'h0); wr_reg(3'd6, 32'hFF);
    pin_in = 8'h00;
    cycles(SYNC + 3);
    wr_reg(3'd6, 32'hFF); wr_reg(3'd5, 32'h1); wr_reg(3'd4, 32'h1);
    pin_in = 8'h01;
    repeat (SYNC) @(posedge clk);
    #1 rd_reg(3'd6, rd); chk("status before SYNC+1", rd, 32'h0);
    @(posedge clk); #1;
    rd_reg(3'd6, rd); chk("status at SYNC+1", rd, 32'h1);
    chk("irq on rise", 32'(irq), 32'h1);
    wr_reg(3'd6, 32'h1);
    chk("irq after w1c", 32'(irq), 32'h0);
    pin_in = 8'h00;
    cycles(SYNC + 3);
    rd_reg(3'd6, rd); chk("falling ignored", rd, 32'h0);

    // Both-edge pin 3 with IE off, then IE mask/unmask
    wr_reg(3'd4, 32'h0); wr_reg(3'd5, 32'hC0);
    pin_in = 8'h08; cycles(SYNC + 3);
    pin_in = 8'h00; cycles(SYNC + 3);
    rd_reg(3'd6, rd); chk("both-edge status", rd, 32'h08);
    chk("irq masked", 32'(irq), 32'h0);
    rd_reg(3'd7, rd); chk("pend masked", rd, 32'h0800_0000);
    wr_reg(3'd4, 32'h08);
    chk("irq enabled", 32'(irq), 32'h1);
    rd_reg(3'd7, rd); chk("pend enabled", rd, 32'h0800_0008);
    wr_reg(3'd4, 32'h0);
    chk("irq ie cleared", 32'(irq), 32'h0);
    rd_reg(3'd6, rd); chk("status retained", rd, 32'h08);
    wr_reg(3'd4, 32'h08);
    chk("irq re-enabled", 32'(irq), 32'h1);

    // W1C landing on the same edge as a new event: set wins
    pin_in = 8'h08;
    repeat (SYNC) @(posedge clk);
    #1 bus.sel = 1; bus.wr = 1; bus.adr = 3'd6; bus.wdata = 32'h08;
    @(posedge clk); #1;
    bus.sel = 0; bus.wr = 0;
    rd_reg(3'd6, rd); chk("set beats w1c", rd, 32'h08);
    wr_reg(3'd6, 32'h08);
    rd_reg(3'd6, rd); chk("w1c clears", rd, 32'h0);
    chk("irq after clear", 32'(irq), 32'h0);

    // Asynchronous reset between edges
    wr_reg(3'd1, 32'hFF);
    chk("oe written", 32'(pin_oe), 32'hFF);
    pin_in = 8'h00; cycles(SYNC + 3);
    rd_reg(3'd6, rd); chk("status before rst", rd, 32'h08);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("async rst pin_oe", 32'(pin_oe), 32'h0);
    chk("async rst irq", 32'(irq), 32'h0);
    rd_reg(3'd6, rd); chk("async rst status", rd, 32'h0);
    @(negedge clk) rst = 1'b0;

    // 16-pin build
    @(negedge clk);
    bus16.sel = 1; bus16.wr = 1; bus16.adr = 3'd5; bus16.wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus16.wr = 0;
    #1 chk("w16 mode", bus16.rdata, 32'hFFFF_FFFF);
    bus16.adr = 3'd7;
    #1 chk("w16 pend width", 32'(bus16.rdata[31:24]), 32'd16);
    bus16.sel = 0;

    // Random run against the reference model
    @(negedge clk) rst = 1'b1; pin_in = 8'h00;
    m_reset();
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd pin_out", 32'(pin_out), 32'(m_out));
      chk("rnd pin_oe", 32'(pin_oe), 32'(m_oe));
      chk("rnd irq", 32'(irq), 32'(|(m_st & m_ie)));
      s = 1'($urandom_range(1));
      w = 1'($urandom_range(1));
      a = 3'($urandom_range(7));
      d = $urandom;
      if (a == 3'd5 && $urandom_range(1) == 1) d = 32'hFFFF;
      bus.sel = s; bus.wr = w; bus.adr = a; bus.wdata = d;
      if ($urandom_range(2) == 0) pin_in = pin_in ^ (8'h1 << $urandom_range(7));
      #1;
      if (s) chk($sformatf("rnd rdata adr%0d", a), bus.rdata, m_read(a));
      @(posedge clk);
      m_edge(s, w, a, d, pin_in);
    end
    bus.sel = 0; bus.wr = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
